// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter
//
// Shares a single I2C byte-transaction master between NREQ requesters.
// Requests are arbitrated round-robin. One byte transaction is in flight at a
// time. A watchdog aborts any transaction that the master never completes.
//
// Optional build macro: I2C_ARB_STATS_EN adds the stat_txn and stat_err
// response counters. Both are 16 bits and saturate at 16'hFFFF.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   req_valid       per-requester request pending
//   req_ready       one-hot accept pulse
//   req_op          per-requester op (1 = read, 0 = write)
//   req_addr        7 bits per requester, requester i at [7i+6:7i]
//   req_wdata       8 bits per requester, requester i at [8i+7:8i]
//   rsp_valid       one-hot response pulse
//   rsp_rdata       read byte (0 for writes and on error)
//   rsp_err         ack error or timeout, qualified by rsp_valid
//   rsp_timeout     error was caused by the watchdog, qualified by rsp_valid
//   grant_id        current or last granted requester
//   m_newd          start pulse to the master
//   m_op/addr/din   latched transaction fields to the master
//   m_abort         abort pulse to the master
//   m_busy          master transaction in progress
//   m_done          master completion pulse
//   m_ack_err       slave NACK, valid with m_done
//   m_dout          read byte, valid with m_done
//   stat_txn/err    (I2C_ARB_STATS_EN only) response and error counters
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | sampling req_valid, grant the first requester from the RR pointer
// ISSUE     | holding the latched request until the master is not busy
// WAIT_DONE | transaction running, watchdog counting
// RESP      | rsp_valid pulse to the granted requester
module i2c_master_arbiter #(
   parameter int NREQ        = 4,
   parameter int TIMEOUT_CYC = 200000,
   parameter int GID_W       = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ-1:0]       req_op,
   input  logic [NREQ*7-1:0]     req_addr,
   input  logic [NREQ*8-1:0]     req_wdata,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [7:0]            rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic [GID_W-1:0]      grant_id,
   output logic                  m_newd,
   output logic                  m_op,
   output logic [6:0]            m_addr,
   output logic [7:0]            m_din,
   output logic                  m_abort,
   input  logic                  m_busy,
   input  logic                  m_done,
   input  logic                  m_ack_err,
   input  logic [7:0]            m_dout
`ifdef I2C_ARB_STATS_EN
   ,
   output logic [15:0]           stat_txn,
   output logic [15:0]           stat_err
`endif
);

   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;

   state_t            state_q, state_d;
   logic [GID_W-1:0]  ptr_q, ptr_d;
   logic [GID_W-1:0]  grant_id_q, grant_id_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic [NREQ-1:0]   req_ready_q, req_ready_d;
   logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [7:0]        rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rsp_timeout_q, rsp_timeout_d;
   logic              m_newd_q, m_newd_d;
   logic              m_op_q, m_op_d;
   logic [6:0]        m_addr_q, m_addr_d;
   logic [7:0]        m_din_q, m_din_d;
   logic              m_abort_q, m_abort_d;

   logic              found;
   int                sel;
   int                idx;

   // First pending requester at or above the RR pointer, wrapping around.
   always_comb begin
      found = 1'b0;
      sel   = 0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr_q) + k) % NREQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      grant_id_d    = grant_id_q;
      wd_d          = wd_q;
      req_ready_d   = '0;
      rsp_valid_d   = '0;
      rsp_rdata_d   = 8'h00;
      rsp_err_d     = 1'b0;
      rsp_timeout_d = 1'b0;
      m_newd_d      = 1'b0;
      m_abort_d     = 1'b0;
      m_op_d        = m_op_q;
      m_addr_d      = m_addr_q;
      m_din_d       = m_din_q;

      case (state_q)
         IDLE: begin
            if (found) begin
               req_ready_d[sel] = 1'b1;
               m_op_d           = req_op[sel];
               m_addr_d         = req_addr[7*sel +: 7];
               m_din_d          = req_wdata[8*sel +: 8];
               grant_id_d       = GID_W'(sel);
               ptr_d            = (sel == NREQ - 1) ? '0 : GID_W'(sel + 1);
               state_d          = ISSUE;
            end
         end
         ISSUE: begin
            if (!m_busy) begin
               m_newd_d = 1'b1;
               wd_d     = '0;
               state_d  = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            // Completion takes priority over a watchdog expiry in the same cycle.
            if (m_done) begin
               rsp_valid_d[grant_id_q] = 1'b1;
               rsp_rdata_d             = m_op_q ? m_dout : 8'h00;
               rsp_err_d               = m_ack_err;
               state_d                 = RESP;
            end else begin
               wd_d = wd_q + WD_W'(1);
               // wd_q + 1 reaches TIMEOUT_CYC-1 on this edge.
               if (wd_q == WD_W'(TIMEOUT_CYC - 2)) begin
                  m_abort_d               = 1'b1;
                  rsp_valid_d[grant_id_q] = 1'b1;
                  rsp_err_d               = 1'b1;
                  rsp_timeout_d           = 1'b1;
                  state_d                 = RESP;
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         grant_id_q    <= '0;
         wd_q          <= '0;
         req_ready_q   <= '0;
         rsp_valid_q   <= '0;
         rsp_rdata_q   <= 8'h00;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         m_newd_q      <= 1'b0;
         m_op_q        <= 1'b0;
         m_addr_q      <= 7'h00;
         m_din_q       <= 8'h00;
         m_abort_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         grant_id_q    <= grant_id_d;
         wd_q          <= wd_d;
         req_ready_q   <= req_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         m_newd_q      <= m_newd_d;
         m_op_q        <= m_op_d;
         m_addr_q      <= m_addr_d;
         m_din_q       <= m_din_d;
         m_abort_q     <= m_abort_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;
   assign grant_id    = grant_id_q;
   assign m_newd      = m_newd_q;
   assign m_op        = m_op_q;
   assign m_addr      = m_addr_q;
   assign m_din       = m_din_q;
   assign m_abort     = m_abort_q;

`ifdef I2C_ARB_STATS_EN
   logic [15:0] stat_txn_q, stat_txn_d;
   logic [15:0] stat_err_q, stat_err_d;

   // The response registers are valid while in RESP.
   always_comb begin
      stat_txn_d = stat_txn_q;
      stat_err_d = stat_err_q;
      if (state_q == RESP) begin
         if (stat_txn_q != 16'hFFFF) stat_txn_d = stat_txn_q + 16'd1;
         if (rsp_err_q && stat_err_q != 16'hFFFF) stat_err_d = stat_err_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_txn_q <= 16'h0000;
         stat_err_q <= 16'h0000;
      end else begin
         stat_txn_q <= stat_txn_d;
         stat_err_q <= stat_err_d;
      end
   end

   assign stat_txn = stat_txn_q;
   assign stat_err = stat_err_q;
`endif

endmodule

// File: tb/tb_i2c_master_arbiter.sv
module tb_i2c_master_arbiter;

   localparam int NREQ = 4;
   localparam int TOC  = 50;

   typedef struct {
      int         id;
      logic [7:0] rdata;
      logic       err;
      logic       to;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   req_op = '0;
   logic [NREQ*7-1:0] req_addr = '0;
   logic [NREQ*8-1:0] req_wdata = '0;
   logic [NREQ-1:0]   rsp_valid;
   logic [7:0]        rsp_rdata;
   logic              rsp_err;
   logic              rsp_timeout;
   logic [1:0]        grant_id;
   logic              m_newd;
   logic              m_op;
   logic [6:0]        m_addr;
   logic [7:0]        m_din;
   logic              m_abort;
   logic              m_busy = 1'b0;
   logic              m_done = 1'b0;
   logic              m_ack_err = 1'b0;
   logic [7:0]        m_dout = 8'h00;
`ifdef I2C_ARB_STATS_EN
   logic [15:0]       stat_txn;
   logic [15:0]       stat_err;
`endif

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   done_cyc = -10;
   int   abort_cnt = 0;
   int   rsp_cnt [NREQ];
   int   master_lat = 2;
   bit   master_nack = 1'b0;
   bit   master_hang = 1'b0;
   exp_t exp_q [$];

   i2c_master_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TOC), .GID_W(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .rsp_timeout(rsp_timeout), .grant_id(grant_id),
      .m_newd(m_newd), .m_op(m_op), .m_addr(m_addr), .m_din(m_din),
      .m_abort(m_abort), .m_busy(m_busy), .m_done(m_done),
      .m_ack_err(m_ack_err), .m_dout(m_dout)
`ifdef I2C_ARB_STATS_EN
      , .stat_txn(stat_txn), .stat_err(stat_err)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Master model: answers each m_newd after master_lat cycles unless hung.
   initial begin
      forever begin
         @(negedge clk);
         if (m_newd === 1'b1 && !master_hang) begin
            repeat (master_lat) @(negedge clk);
            m_done    = 1'b1;
            m_dout    = {1'b0, m_addr};
            m_ack_err = master_nack;
            done_cyc  = cyc;
            @(negedge clk);
            m_done    = 1'b0;
            m_ack_err = 1'b0;
            m_dout    = 8'h00;
         end
      end
   end

   // Response scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (m_abort === 1'b1) abort_cnt++;
         if (rst === 1'b0 && rsp_valid !== '0) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_rsp rsp_valid=%b", rsp_valid);
            end else begin
               e = exp_q.pop_front();
               checks++;
               if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !==
                   {4'(1 << e.id), e.rdata, e.err, e.to}) begin
                  failures++;
                  $display("FAIL rsp got valid=%b rdata=%h err=%b to=%b want valid=%b rdata=%h err=%b to=%b",
                           rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
                           4'(1 << e.id), e.rdata, e.err, e.to);
               end
               if (!e.to) begin
                  checks++;
                  if (cyc !== done_cyc + 1) begin
                     failures++;
                     $display("FAIL rsp_latency got cycle=%0d want %0d", cyc, done_cyc + 1);
                  end
               end
               rsp_cnt[e.id]++;
            end
         end
      end
   end

   task automatic set_req(input int id, input logic op, input logic [6:0] a, input logic [7:0] w);
      req_op[id]          = op;
      req_addr[7*id +: 7] = a;
      req_wdata[8*id +: 8] = w;
   endtask

   task automatic wait_ready(input string nm, input logic [NREQ-1:0] want);
      int n = 0;
      while (req_ready === '0 && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (req_ready !== want) begin
         failures++;
         $display("FAIL %s req_ready got %b want %b", nm, req_ready, want);
      end
   endtask

   task automatic wait_drain(input string nm);
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
      if (exp_q.size() != 0) begin
         checks++; failures++;
         $display("FAIL %s drain got pending=%0d want 0", nm, exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, grant_id,
           m_newd, m_op, m_addr, m_din, m_abort} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got nonzero ready=%b rsp=%b newd=%b addr=%h din=%h",
                  req_ready, rsp_valid, m_newd, m_addr, m_din);
      end
      rst = 1'b0;
      @(negedge clk);
      m_done = 1'b1; m_dout = 8'h5A;
      @(negedge clk);
      m_done = 1'b0; m_dout = 8'h00;
      @(negedge clk);
      checks++;
      if (rsp_valid !== '0 || m_newd !== 1'b0) begin
         failures++;
         $display("FAIL done_in_idle got rsp_valid=%b newd=%b want 0", rsp_valid, m_newd);
      end
   endtask

   task automatic test_single_read();
      master_lat = 3; master_nack = 1'b0; master_hang = 1'b0;
      set_req(1, 1'b1, 7'h15, 8'h00);
      req_valid = 4'b0010;
      @(negedge clk);
      wait_ready("read", 4'b0010);
      exp_q.push_back('{1, 8'h15, 1'b0, 1'b0});
      req_valid = '0;
      @(negedge clk);
      checks++;
      if ({m_newd, m_op, m_addr} !== {1'b1, 1'b1, 7'h15}) begin
         failures++;
         $display("FAIL read_issue got newd=%b op=%b addr=%h want 1 1 15", m_newd, m_op, m_addr);
      end
      wait_drain("read");
   endtask

   task automatic test_write();
      master_lat = 2; master_nack = 1'b1;
      set_req(0, 1'b0, 7'h20, 8'hA5);
      req_valid = 4'b0001;
      @(negedge clk);
      wait_ready("write", 4'b0001);
      exp_q.push_back('{0, 8'h00, 1'b1, 1'b0});
      req_valid = '0;
      @(negedge clk);
      checks++;
      if ({m_newd, m_op, m_addr, m_din} !== {1'b1, 1'b0, 7'h20, 8'hA5}) begin
         failures++;
         $display("FAIL write_issue got newd=%b op=%b addr=%h din=%h want 1 0 20 a5",
                  m_newd, m_op, m_addr, m_din);
      end
      wait_drain("write");
      master_nack = 1'b0;
   endtask

   task automatic test_round_robin();
      do_reset();
      master_lat = 2;
      for (int i = 0; i < NREQ; i++) begin
         set_req(i, 1'b1, 7'(8'h30 + i), 8'h00);
         rsp_cnt[i] = 0;
      end
      req_valid = '1;
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         wait_ready("rr", 4'(1 << (k % NREQ)));
         exp_q.push_back('{k % NREQ, 8'(8'h30 + (k % NREQ)), 1'b0, 1'b0});
         if (k == 7) req_valid = '0;
         @(negedge clk);
      end
      wait_drain("rr");
      for (int i = 0; i < NREQ; i++) begin
         checks++;
         if (rsp_cnt[i] !== 2) begin
            failures++;
            $display("FAIL rr_count req%0d got %0d want 2", i, rsp_cnt[i]);
         end
      end
   endtask

   task automatic test_timeout();
      int c0, c1, n, a0;
      master_hang = 1'b1;
      a0 = abort_cnt;
      set_req(2, 1'b0, 7'h33, 8'h77);
      req_valid = 4'b0100;
      @(negedge clk);
      wait_ready("timeout", 4'b0100);
      exp_q.push_back('{2, 8'h00, 1'b1, 1'b1});
      req_valid = '0;
      n = 0;
      while (m_newd !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      c0 = cyc;
      n = 0;
      while (m_abort !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      c1 = cyc;
      checks++;
      if (m_abort !== 1'b1 || c1 - c0 !== TOC - 1) begin
         failures++;
         $display("FAIL abort_delay got %0d abort=%b want %0d", c1 - c0, m_abort, TOC - 1);
      end
      wait_drain("timeout");
      checks++;
      if (abort_cnt - a0 !== 1) begin
         failures++;
         $display("FAIL abort_count got %0d want 1", abort_cnt - a0);
      end
      master_hang = 1'b0;
   endtask

   task automatic test_done_at_expiry();
      int a0;
      a0 = abort_cnt;
      master_lat = TOC - 2;
      set_req(2, 1'b1, 7'h2A, 8'h00);
      req_valid = 4'b0100;
      @(negedge clk);
      wait_ready("expiry", 4'b0100);
      exp_q.push_back('{2, 8'h2A, 1'b0, 1'b0});
      req_valid = '0;
      wait_drain("expiry");
      checks++;
      if (abort_cnt !== a0) begin
         failures++;
         $display("FAIL expiry_abort got %0d aborts want 0", abort_cnt - a0);
      end
      master_lat = 2;
   endtask

   task automatic test_busy_hold();
      int bad = 0;
      m_busy = 1'b1;
      set_req(3, 1'b1, 7'h55, 8'h00);
      req_valid = 4'b1000;
      @(negedge clk);
      wait_ready("busy", 4'b1000);
      exp_q.push_back('{3, 8'h55, 1'b0, 1'b0});
      req_valid = '0;
      repeat (30) begin
         @(negedge clk);
         if (m_newd !== 1'b0 || m_addr !== 7'h55) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL busy_hold got %0d bad cycles want 0", bad);
      end
      m_busy = 1'b0;
      @(negedge clk);
      checks++;
      if (m_newd !== 1'b1 || m_addr !== 7'h55) begin
         failures++;
         $display("FAIL busy_release got newd=%b addr=%h want 1 55", m_newd, m_addr);
      end
      wait_drain("busy");
   endtask

   task automatic test_reset_mid();
      int a0, n;
      master_hang = 1'b1;
      set_req(2, 1'b0, 7'h11, 8'h22);
      req_valid = 4'b0100;
      @(negedge clk);
      wait_ready("rstmid_pre", 4'b0100);
      req_valid = '0;
      n = 0;
      while (m_newd !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, grant_id,
           m_newd, m_op, m_addr, m_din, m_abort} !== '0) begin
         failures++;
         $display("FAIL rstmid_outputs got nonzero grant=%h addr=%h din=%h", grant_id, m_addr, m_din);
      end
      rst = 1'b0;
      a0 = abort_cnt;
      repeat (TOC + 10) @(negedge clk);
      checks++;
      if (abort_cnt !== a0) begin
         failures++;
         $display("FAIL rstmid_abort got %0d aborts want 0", abort_cnt - a0);
      end
      master_hang = 1'b0;
      master_lat = 2;
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 7'(8'h40 + i), 8'h00);
      req_valid = '1;
      @(negedge clk);
      wait_ready("rstmid_first", 4'b0001);
      exp_q.push_back('{0, 8'h40, 1'b0, 1'b0});
      req_valid = '0;
      wait_drain("rstmid");
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write();
      test_round_robin();
      test_timeout();
      test_done_at_expiry();
      test_busy_hold();
      test_reset_mid();
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/i2c_master_arbiter.md
Name: i2c_master_arbiter

Overview:
- Shares one I2C master engine between NREQ independent requesters (CPU shim, config loader, test sequencer).
- Round-robin arbitration; one byte transaction at a time. The block drives the engine's newd/op/addr/din and routes the returned read data and ack error to the granted requester.
- A watchdog aborts transactions that never complete, so a hung bus or absent slave cannot stall the design.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 200000, clk cycles from newd pulse to forced abort (5 ms at 40 MHz).
- GID_W, 2, width of grant id; must equal clog2(NREQ).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester request pending.
- req_ready  out  NREQ  one-hot one-cycle accept pulse.
- req_op  in  NREQ  1 = read, 0 = write.
- req_addr  in  NREQ*7  7-bit slave address, requester i at bits [7i+6:7i].
- req_wdata  in  NREQ*8  write byte, requester i at bits [8i+7:8i].
- rsp_valid  out  NREQ  one-hot one-cycle response pulse.
- rsp_rdata  out  8  read byte; 0 for writes and on error.
- rsp_err  out  1  ack error or timeout; qualified by rsp_valid.
- rsp_timeout  out  1  error cause was the watchdog; qualified by rsp_valid.
- grant_id  out  GID_W  id of the current or last granted requester.
- m_newd  out  1  one-cycle start pulse to the master.
- m_op  out  1  latched op.
- m_addr  out  7  latched address.
- m_din  out  8  latched write byte.
- m_abort  out  1  one-cycle abort pulse to the master.
- m_busy  in  1  master transaction in progress.
- m_done  in  1  one-cycle completion pulse.
- m_ack_err  in  1  slave NACK, valid with m_done.
- m_dout  in  8  read byte, valid with m_done.

Behaviour:
- Reset: every output 0; state IDLE; RR pointer 0; watchdog 0. Reset mid-transaction drops the in-flight request with no response and pulses nothing.
- FSM states: IDLE, ISSUE, WAIT_DONE, RESP.
- IDLE:
  - If any req_valid, select the first set bit searching from the RR pointer upward with wrap.
  - Same cycle: pulse req_ready[i], latch op/addr/wdata into the m_* registers, set grant_id = i, set pointer = (i+1) mod NREQ, go to ISSUE.
  - No valid: stay in IDLE.
- ISSUE:
  - While m_busy = 1, hold.
  - When m_busy = 0, pulse m_newd for exactly one cycle, clear the watchdog, go to WAIT_DONE.
  - m_op/m_addr/m_din stay stable from latch until RESP exit.
- WAIT_DONE:
  - Watchdog increments each cycle.
  - m_done = 1: capture rdata = op ? m_dout : 0; err = m_ack_err; timeout = 0; go to RESP.
  - Watchdog reaches TIMEOUT_CYC-1 without done: pulse m_abort; set rdata = 0, err = 1, timeout = 1; go to RESP.
  - m_done on the same cycle as expiry: done wins, no abort.
- RESP: drive rsp_valid[grant_id] for one cycle with rsp_rdata/rsp_err/rsp_timeout, then go to IDLE. The earliest next grant is the following cycle.
- Latency: request accepted to m_newd is 1 cycle when the master is idle. m_done to rsp_valid is 1 cycle.
- Requesters may drop req_valid before ready without effect. Lines are re-sampled only in IDLE.
- m_done seen outside WAIT_DONE is ignored.
- Fairness: with all NREQ requesting continuously, each is granted once every NREQ transactions.

Optional Feature:
- Macro: I2C_ARB_STATS_EN.
- Defined: adds outputs stat_txn (16 bits, responses issued) and stat_err (16 bits, responses with rsp_err = 1). Both increment in RESP, saturate at 16'hFFFF, and reset to 0.
- Undefined: those ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Single read: req 1 asserts valid, op = 1, addr = 7'h15; master returns done, dout = 8'h15, ack_err = 0.
  → req_ready[1], then m_newd with m_addr = 7'h15, then rsp_valid[1] with rdata = 8'h15, err = 0.
- Write: req 0, op = 0, addr = 7'h20, wdata = 8'hA5; master returns done, ack_err = 1.
  → m_din = 8'hA5; rsp_valid[0], rdata = 0, err = 1, timeout = 0.
- Round-robin: all 4 requesting continuously for 8 transactions.
  → grant order 0,1,2,3,0,1,2,3; each requester gets exactly 2 responses.
- Timeout: TIMEOUT_CYC = 50, master never pulses done.
  → m_abort pulses 49 cycles after m_newd; rsp_err = 1, rsp_timeout = 1, rdata = 0.
- Busy hold: m_busy held high 30 cycles after grant.
  → m_newd first appears the cycle after m_busy falls; m_addr stable throughout.
- Reset mid-WAIT_DONE: rst for 1 cycle.
  → no rsp_valid, all outputs 0; the next request is granted to requester 0 first.
